// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: requester ids, tag-entry layout and shared constants
package mem_port_arbiter_pkg;
  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LD = 2'd1;
  localparam logic [1:0] REQ_ST = 2'd2;
  typedef struct packed {
    logic kill;
    logic [1:0] id;
  } tag_t;
  localparam logic [31:0] TOHOST_ADDR = 32'h3000_0000;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order requester-id FIFO with flush-kill of fetch/load entries
module arb_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_id,
  input  logic       pop,
  input  logic       kill,
  output tag_t       head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  tag_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  // a flush in the pop cycle must also suppress the entry leaving now
  assign head = {mem[rptr].kill | (kill & (mem[rptr].id != REQ_ST)), mem[rptr].id};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && mem[i].id != REQ_ST) mem[i].kill <= 1'b1;
      if (push) begin
        mem[wptr] <= {1'b0, push_id};
        wptr <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/load/store arbitration onto one memory bus with in-order response routing
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_req_valid,
  input  logic [29:0] fetch_req_addr,
  output logic        fetch_req_ready,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  output logic        ld_req_ready,
  input  logic        st_req_valid,
  input  logic [31:0] st_req_addr,
  input  logic [31:0] st_req_wdata,
  input  logic [3:0]  st_req_wmask,
  output logic        st_req_ready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        fetch_resp_valid,
  output logic        ld_resp_valid,
  output logic        st_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_orphan
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  logic [CW-1:0] f_cnt, ld_cnt;
  logic f_sat, ld_sat, f_ok, ld_ok, f_top, ld_top;
  logic stage_load, can_grant, pop, full, empty, any_grant;
  logic [1:0] grant_id;
  tag_t head;
  assign stage_load = ~mem_req_valid | mem_req_ready;
  assign pop = mem_resp_valid & ~empty;
  assign can_grant = rst & stage_load & (~full | pop);
  assign f_sat = f_cnt == CW'(STARVE_LIM);
  assign ld_sat = ld_cnt == CW'(STARVE_LIM);
  assign f_ok = fetch_req_valid & ~flush;
  assign ld_ok = ld_req_valid & ~flush;
  assign f_top = f_ok & f_sat;
  assign ld_top = ld_ok & ld_sat;
  // starved load > starved fetch > store > load > fetch
  assign ld_req_ready = can_grant & ld_ok & (ld_sat | (~f_top & ~st_req_valid));
  assign fetch_req_ready = can_grant & f_ok & ~ld_top & (f_sat | (~st_req_valid & ~ld_ok));
  assign st_req_ready = can_grant & st_req_valid & ~ld_top & ~f_top;
  assign any_grant = fetch_req_ready | ld_req_ready | st_req_ready;
  assign grant_id = st_req_ready ? REQ_ST : ld_req_ready ? REQ_LD : REQ_FETCH;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else if (stage_load) begin
      mem_req_valid <= any_grant;
      mem_req_write <= st_req_ready;
      mem_req_addr <= st_req_ready ? st_req_addr : ld_req_ready ? ld_req_addr : {fetch_req_addr, 2'b00};
      mem_req_wdata <= st_req_ready ? st_req_wdata : '0;
      mem_req_wmask <= st_req_ready ? st_req_wmask : '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_cnt <= '0;
      ld_cnt <= '0;
      resp_orphan <= 1'b0;
    end else begin
      f_cnt <= (~fetch_req_valid | fetch_req_ready) ? '0 : f_sat ? f_cnt : f_cnt + CW'(1);
      ld_cnt <= (~ld_req_valid | ld_req_ready) ? '0 : ld_sat ? ld_cnt : ld_cnt + CW'(1);
      if (mem_resp_valid & empty) resp_orphan <= 1'b1;
    end
  end
  arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk(clk),
    .rst(rst),
    .push(any_grant),
    .push_id(grant_id),
    .pop(pop),
    .kill(flush),
    .head(head),
    .full(full),
    .empty(empty)
  );
  assign fetch_resp_valid = pop & ~head.kill & (head.id == REQ_FETCH);
  assign ld_resp_valid = pop & ~head.kill & (head.id == REQ_LD);
  assign st_resp_valid = pop & ~head.kill & (head.id == REQ_ST);
  assign resp_rdata = mem_resp_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 0, rst = 0, flush = 0;
  logic fetch_req_valid = 0, ld_req_valid = 0, st_req_valid = 0;
  logic [29:0] fetch_req_addr = '0;
  logic [31:0] ld_req_addr = '0, st_req_addr = '0, st_req_wdata = '0;
  logic [3:0] st_req_wmask = '0;
  logic fetch_req_ready, ld_req_ready, st_req_ready;
  logic mem_req_valid, mem_req_write, mem_req_ready = 0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0] mem_req_wmask;
  logic mem_resp_valid = 0;
  logic [31:0] mem_resp_rdata = '0;
  logic fetch_resp_valid, ld_resp_valid, st_resp_valid, resp_orphan;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr), .fetch_req_ready(fetch_req_ready),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_wdata(st_req_wdata),
    .st_req_wmask(st_req_wmask), .st_req_ready(st_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .fetch_resp_valid(fetch_resp_valid), .ld_resp_valid(ld_resp_valid), .st_resp_valid(st_resp_valid),
    .resp_rdata(resp_rdata), .resp_orphan(resp_orphan)
  );

  typedef struct packed {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] m;
  } bus_t;

  bus_t exp_bus[$];
  logic [33:0] exp_resp[$];
  logic [31:0] pend[$];
  int n_cmp = 0, n_bad = 0;
  bit auto_resp = 0, man_req = 0;
  bus_t m_e;
  logic [33:0] m_r;
  logic [1:0] m_kind;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic bus_t bx(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    return '{w: w, a: a, d: d, m: m};
  endfunction

  // memory model answers every accepted request with addr+1, in order
  always @(negedge clk) if (rst) begin
    if (mem_req_valid && mem_req_ready) begin
      pend.push_back(mem_req_addr + 32'd1);
      if (exp_bus.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bus_unexpected: got addr %h, required no request", mem_req_addr);
      end else begin
        m_e = exp_bus.pop_front();
        chk("bus_write", mem_req_write, m_e.w);
        chk("bus_addr", mem_req_addr, m_e.a);
        chk("bus_wdata", mem_req_wdata, m_e.d);
        chk("bus_wmask", mem_req_wmask, m_e.m);
      end
    end
    if (fetch_resp_valid || ld_resp_valid || st_resp_valid) begin
      m_kind = st_resp_valid ? 2'd2 : ld_resp_valid ? 2'd1 : 2'd0;
      chk("resp_onehot", 32'($countones({fetch_resp_valid, ld_resp_valid, st_resp_valid})), 1);
      if (exp_resp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got kind %0d data %h, required no response", m_kind, resp_rdata);
      end else begin
        m_r = exp_resp.pop_front();
        chk("resp_kind", m_kind, m_r[33:32]);
        chk("resp_data", resp_rdata, m_r[31:0]);
      end
    end
  end

  // sole driver of the response bus
  always @(posedge clk) begin
    #1;
    if ((auto_resp || man_req) && pend.size() > 0) begin
      mem_resp_valid = 1;
      mem_resp_rdata = pend.pop_front();
    end else begin
      mem_resp_valid = man_req;
      mem_resp_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_bus.size() > 0 || exp_resp.size() > 0) && i < 100) begin
      @(posedge clk);
      i++;
    end
    if (i >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d bus / %0d resp pending, required 0", exp_bus.size(), exp_resp.size());
      exp_bus.delete();
      exp_resp.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required $finish");
    $fatal(1);
  end

  initial begin
    st_req_valid = 1;
    st_req_addr = TOHOST_ADDR;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_st_ready", st_req_ready, 0);
    chk("rst_st_resp_valid", st_resp_valid, 0);
    chk("rst_orphan", resp_orphan, 0);
    st_req_valid = 0;
    auto_resp = 1;
    @(posedge clk);
    #1 rst = 1;
    mem_req_ready = 1;
    // store beats load, load follows next cycle
    tick();
    st_req_valid = 1; st_req_addr = TOHOST_ADDR; st_req_wdata = 32'h1; st_req_wmask = 4'hF;
    ld_req_valid = 1; ld_req_addr = 32'h100;
    exp_bus.push_back(bx(1, TOHOST_ADDR, 32'h1, 4'hF));
    exp_bus.push_back(bx(0, 32'h100, 0, 0));
    exp_resp.push_back({2'd2, 32'h3000_0001});
    exp_resp.push_back({2'd1, 32'h101});
    settle();
    chk("t1_st_ready", st_req_ready, 1);
    chk("t1_ld_ready", ld_req_ready, 0);
    tick();
    st_req_valid = 0;
    settle();
    chk("t1_ld_ready_next", ld_req_ready, 1);
    chk("t1_st_ready_next", st_req_ready, 0);
    tick();
    ld_req_valid = 0;
    drain();
    // fetch starved behind a store stream
    tick();
    st_req_valid = 1; st_req_addr = 32'h200; st_req_wdata = 32'h2; st_req_wmask = 4'h3;
    fetch_req_valid = 1; fetch_req_addr = 30'h40;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) tick();
      if (i == 9) begin
        exp_bus.push_back(bx(0, 32'h100, 0, 0));
        exp_resp.push_back({2'd0, 32'h101});
      end else begin
        exp_bus.push_back(bx(1, 32'h200, 32'h2, 4'h3));
        exp_resp.push_back({2'd2, 32'h201});
      end
      settle();
      chk($sformatf("t2_fetch_ready_c%0d", i), fetch_req_ready, i == 9);
      chk($sformatf("t2_st_ready_c%0d", i), st_req_ready, i != 9);
    end
    tick();
    st_req_valid = 0;
    fetch_req_valid = 0;
    drain();
    // bus back-pressure holds the request stable
    tick();
    mem_req_ready = 0;
    ld_req_valid = 1; ld_req_addr = 32'h300;
    exp_bus.push_back(bx(0, 32'h300, 0, 0));
    exp_bus.push_back(bx(0, 32'h304, 0, 0));
    exp_resp.push_back({2'd1, 32'h301});
    exp_resp.push_back({2'd1, 32'h305});
    settle();
    chk("t3_ld_ready_first", ld_req_ready, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      ld_req_addr = 32'h304;
      settle();
      chk($sformatf("t3_ld_ready_stall%0d", i), ld_req_ready, 0);
      chk($sformatf("t3_valid_stall%0d", i), mem_req_valid, 1);
      chk($sformatf("t3_addr_stall%0d", i), mem_req_addr, 32'h300);
    end
    tick();
    mem_req_ready = 1;
    settle();
    chk("t3_ld_ready_accept", ld_req_ready, 1);
    tick();
    ld_req_valid = 0;
    drain();
    // tag FIFO full, then push with same-cycle pop
    settle();
    auto_resp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ld_req_valid = 1; ld_req_addr = 32'h400 + 32'(4 * i);
      exp_bus.push_back(bx(0, 32'h400 + 32'(4 * i), 0, 0));
      exp_resp.push_back({2'd1, 32'h401 + 32'(4 * i)});
      settle();
      chk($sformatf("t4_ld_ready_%0d", i), ld_req_ready, 1);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      ld_req_addr = 32'h410;
      settle();
      chk($sformatf("t4_full_ld_ready_%0d", i), ld_req_ready, 0);
    end
    man_req = 1;
    tick();
    exp_bus.push_back(bx(0, 32'h410, 0, 0));
    exp_resp.push_back({2'd1, 32'h411});
    settle();
    chk("t4_grant_on_pop", ld_req_ready, 1);
    man_req = 0;
    tick();
    ld_req_addr = 32'h414;
    settle();
    chk("t4_still_full", ld_req_ready, 0);
    tick();
    ld_req_valid = 0;
    settle();
    auto_resp = 1;
    drain();
    // flush kills loads, stores survive
    settle();
    auto_resp = 0;
    tick();
    ld_req_valid = 1; ld_req_addr = 32'h500;
    exp_bus.push_back(bx(0, 32'h500, 0, 0));
    settle();
    chk("t5_ld_ready_a", ld_req_ready, 1);
    tick();
    ld_req_valid = 0;
    st_req_valid = 1; st_req_addr = 32'h508; st_req_wdata = 32'h5; st_req_wmask = 4'hF;
    exp_bus.push_back(bx(1, 32'h508, 32'h5, 4'hF));
    exp_resp.push_back({2'd2, 32'h509});
    settle();
    chk("t5_st_ready_a", st_req_ready, 1);
    tick();
    st_req_valid = 0;
    ld_req_valid = 1; ld_req_addr = 32'h504;
    exp_bus.push_back(bx(0, 32'h504, 0, 0));
    settle();
    chk("t5_ld_ready_b", ld_req_ready, 1);
    tick();
    flush = 1;
    ld_req_addr = 32'h50C;
    fetch_req_valid = 1; fetch_req_addr = 30'h50;
    settle();
    chk("t5_flush_ld_ready", ld_req_ready, 0);
    chk("t5_flush_fetch_ready", fetch_req_ready, 0);
    chk("t5_flush_bus_addr", mem_req_addr, 32'h504);
    tick();
    st_req_valid = 1; st_req_addr = 32'h510; st_req_wdata = 32'h6; st_req_wmask = 4'h1;
    exp_bus.push_back(bx(1, 32'h510, 32'h6, 4'h1));
    exp_resp.push_back({2'd2, 32'h511});
    settle();
    chk("t5_flush_st_ready", st_req_ready, 1);
    chk("t5_flush2_ld_ready", ld_req_ready, 0);
    tick();
    flush = 0;
    ld_req_valid = 0;
    fetch_req_valid = 0;
    st_req_valid = 0;
    settle();
    auto_resp = 1;
    drain();
    // orphan response, then asynchronous reset
    settle();
    auto_resp = 0;
    man_req = 1;
    tick();
    settle();
    man_req = 0;
    tick();
    settle();
    chk("t6_orphan_set", resp_orphan, 1);
    tick();
    settle();
    chk("t6_orphan_held", resp_orphan, 1);
    tick();
    mem_req_ready = 0;
    st_req_valid = 1; st_req_addr = 32'h600; st_req_wdata = 32'h7; st_req_wmask = 4'hF;
    settle();
    chk("t6_st_ready", st_req_ready, 1);
    tick();
    settle();
    chk("t6_valid_before_rst", mem_req_valid, 1);
    #1 rst = 0;
    #1;
    chk("t6_async_orphan", resp_orphan, 0);
    chk("t6_async_valid", mem_req_valid, 0);
    chk("t6_async_st_ready", st_req_ready, 0);
    st_req_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    mem_req_ready = 1;
    settle();
    man_req = 1;
    tick();
    settle();
    man_req = 0;
    tick();
    settle();
    chk("t6_orphan_after_rst", resp_orphan, 1);
    chk("end_bus_queue", 32'(exp_bus.size()), 0);
    chk("end_resp_queue", 32'(exp_resp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
